// File: rtl/mem_responder.sv
// Instruction/data memory responder for a simple CPU: fetch port, bidirectional data port,
// loader port, halt mailbox at 0x00FF, sticky range-error flag and saturating write counter.
module mem_responder (
  input  logic        CK,
  input  logic        RST,
  input  logic [15:0] IA,
  output logic [15:0] ID,
  input  logic [15:0] DA,
  inout  wire  [15:0] DD,
  input  logic        RW,
  input  logic        LDE,
  input  logic        LDI,
  input  logic [6:0]  LDA,
  input  logic [15:0] LDD,
  output logic        HALT,
  output logic [15:0] HCODE,
  output logic        ERR,
  output logic [15:0] WCNT
);

  localparam logic [15:0] HALT_ADDR = 16'h00FF;

  logic [15:0] imem_q [128];
  logic [15:0] dmem_q [128];

  logic [15:0] id_q, id_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] hcode_q, hcode_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;

  logic ia_in, da_in, da_halt;
  logic cpu_wr, dmem_we, halt_set, err_set;

  assign ia_in   = (IA[15:7] == 9'd0);
  assign da_in   = (DA[15:7] == 9'd0);
  assign da_halt = (DA == HALT_ADDR);

  // A loader cycle blocks every CPU write, which also resolves same-index collisions.
  assign cpu_wr   = !RW && !LDE && !RST && !halt_q;
  assign dmem_we  = cpu_wr && da_in;
  assign halt_set = cpu_wr && da_halt;
  assign err_set  = cpu_wr && !da_in && !da_halt;

  assign DD = (RW && !RST && !LDE) ? rd_q : 16'hzzzz;

  assign ID    = id_q;
  assign HALT  = halt_q;
  assign HCODE = hcode_q;
  assign ERR   = err_q;
  assign WCNT  = wcnt_q;

  always_comb begin
    id_d    = 16'd0;
    rd_d    = rd_q;
    halt_d  = halt_q | halt_set;
    hcode_d = halt_set ? DD : hcode_q;
    err_d   = err_q | err_set;
    wcnt_d  = wcnt_q;
    if (ia_in && !LDE && !halt_q)
      id_d = imem_q[IA[6:0]];
    if (RW)
      rd_d = da_in ? dmem_q[DA[6:0]] : 16'd0;
    if (dmem_we && (wcnt_q != 16'hFFFF))
      wcnt_d = wcnt_q + 16'd1;
    if (RST) begin
      id_d    = 16'd0;
      rd_d    = 16'd0;
      halt_d  = 1'b0;
      hcode_d = 16'd0;
      err_d   = 1'b0;
      wcnt_d  = 16'd0;
    end
  end

  // Falling-edge update gives the CPU half a cycle of stable data before its rising edge.
  always_ff @(negedge CK) begin
    id_q    <= id_d;
    rd_q    <= rd_d;
    halt_q  <= halt_d;
    hcode_q <= hcode_d;
    err_q   <= err_d;
    wcnt_q  <= wcnt_d;
  end

  // Memory arrays are never reset so a preloaded program survives RST.
  always_ff @(negedge CK) begin
    if (LDE && LDI)
      imem_q[LDA] <= LDD;
    if (LDE && !LDI)
      dmem_q[LDA] <= LDD;
    else if (dmem_we)
      dmem_q[DA[6:0]] <= DD;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder, checked against a rule-level memory model.
module tb_mem_responder;

  logic        CK = 1'b0;
  logic        RST;
  logic [15:0] IA, DA, dd_drv, LDD;
  logic        RW, LDE, LDI;
  logic [6:0]  LDA;
  wire  [15:0] DD;
  logic [15:0] ID, HCODE, WCNT;
  logic        HALT, ERR;

  assign DD = RW ? 16'hzzzz : dd_drv;

  mem_responder dut (
    .CK(CK), .RST(RST), .IA(IA), .ID(ID), .DA(DA), .DD(DD), .RW(RW),
    .LDE(LDE), .LDI(LDI), .LDA(LDA), .LDD(LDD),
    .HALT(HALT), .HCODE(HCODE), .ERR(ERR), .WCNT(WCNT)
  );

  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [15:0] imem_m [128];
  logic [15:0] dmem_m [128];
  logic [15:0] id_m, rd_m, hcode_m;
  int          wcnt_m;
  logic        halt_m, err_m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int a;
    int i;
    a = int'(DA);
    i = int'(IA);
    // Reads see the memory as it was before this edge.
    if (RST || LDE || halt_m || i > 127) id_m = 16'd0;
    else id_m = imem_m[i];
    if (RST) rd_m = 16'd0;
    else if (RW) rd_m = (a <= 127) ? dmem_m[a] : 16'd0;
    if (LDE) begin
      if (LDI) imem_m[LDA] = LDD;
      else     dmem_m[LDA] = LDD;
    end else if (!RW && !RST && !halt_m) begin
      if (a <= 127) begin
        dmem_m[a] = dd_drv;
        if (wcnt_m < 65535) wcnt_m++;
      end else if (a == 255) begin
        halt_m  = 1'b1;
        hcode_m = dd_drv;
      end else begin
        err_m = 1'b1;
      end
    end
    if (RST) begin
      halt_m = 1'b0; hcode_m = 16'd0; err_m = 1'b0; wcnt_m = 0;
    end
  endtask

  task automatic check_all();
    chk("ID", ID, id_m);
    chk("HALT", {15'd0, HALT}, {15'd0, halt_m});
    chk("HCODE", HCODE, hcode_m);
    chk("ERR", {15'd0, ERR}, {15'd0, err_m});
    chk("WCNT", WCNT, wcnt_m[15:0]);
    if (RW && !RST && !LDE) chk("DD", DD, rd_m);
  endtask

  task automatic cycle(input bit do_chk);
    @(negedge CK);
    model_edge();
    #1;
    if (do_chk) check_all();
  endtask

  task automatic idle();
    RST = 1'b0; LDE = 1'b0; LDI = 1'b0; LDA = 7'd0; LDD = 16'd0;
    RW = 1'b1; DA = 16'd0; IA = 16'd0; dd_drv = 16'd0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    idle(); RW = 1'b0; DA = a; dd_drv = d; cycle(1'b1);
  endtask

  task automatic cpu_read(input logic [15:0] a);
    idle(); RW = 1'b1; DA = a; cycle(1'b1);
  endtask

  logic [15:0] prog [8];
  logic [15:0] before3;
  logic [15:0] r;

  initial begin
    prog[0] = 16'h1004; prog[1] = 16'h1103; prog[2] = 16'h2201; prog[3] = 16'h3200;
    prog[4] = 16'h4300; prog[5] = 16'h0513; prog[6] = 16'h3301; prog[7] = 16'hF000;
    halt_m = 1'b0; err_m = 1'b0; hcode_m = 16'd0; wcnt_m = 0; id_m = 16'd0; rd_m = 16'd0;
    idle();

    // Preload both memories under reset; program goes last into IMEM[0..7].
    RST = 1'b1; LDE = 1'b1;
    for (int k = 0; k < 128; k++) begin
      LDI = 1'b0; LDA = 7'(k); LDD = 16'($urandom); cycle(1'b0);
      LDI = 1'b1; LDA = 7'(k); LDD = 16'($urandom); cycle(1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      LDI = 1'b1; LDA = 7'(k); LDD = prog[k]; cycle(1'b1);
    end
    chk("rst_halt", {15'd0, HALT}, 16'd0);
    chk("rst_wcnt", WCNT, 16'd0);

    // Fetch from preloaded program.
    idle(); IA = 16'd5; cycle(1'b1);
    chk("fetch5", ID, 16'h0513);

    // Write then read back; a DD driven by the DUT during the write would corrupt the stored data.
    cpu_read(16'd1);
    cpu_write(16'd0, 16'h0004);
    cpu_read(16'd0);
    chk("rd0", DD, 16'h0004);
    chk("wcnt1", WCNT, 16'd1);

    // Halt mailbox and post-halt write suppression.
    before3 = dmem_m[3];
    idle(); RW = 1'b0; DA = 16'h00FF; dd_drv = 16'h00AA; IA = 16'd5; cycle(1'b1);
    chk("halt", {15'd0, HALT}, 16'd1);
    chk("hcode", HCODE, 16'h00AA);
    chk("halt_wcnt", WCNT, 16'd1);
    idle(); RW = 1'b0; DA = 16'd3; dd_drv = 16'h1234; IA = 16'd5; cycle(1'b1);
    chk("halt_id", ID, 16'd0);
    cpu_read(16'd3);
    chk("halt_dmem3", DD, before3);

    // Range error after a reset.
    idle(); RST = 1'b1; cycle(1'b1);
    r = dmem_m[0];
    cpu_write(16'h0100, 16'hBEEF);
    chk("err", {15'd0, ERR}, 16'd1);
    chk("err_wcnt", WCNT, 16'd0);
    cpu_read(16'd0);
    chk("err_nochg", DD, r);
    cpu_read(16'h0200);
    chk("rd_oor", DD, 16'd0);
    idle(); IA = 16'h0080; cycle(1'b1);
    chk("id_oor", ID, 16'd0);

    // Loader and CPU collide on index 9.
    idle(); RST = 1'b1; cycle(1'b1);
    idle(); LDE = 1'b1; LDI = 1'b0; LDA = 7'd9; LDD = 16'h1111;
    RW = 1'b0; DA = 16'd9; dd_drv = 16'h2222; cycle(1'b1);
    cpu_read(16'd9);
    chk("coll_dmem9", DD, 16'h1111);
    chk("coll_wcnt", WCNT, 16'd0);

    // Reset coinciding with a halt write.
    idle(); RST = 1'b1; RW = 1'b0; DA = 16'h00FF; dd_drv = 16'h00CC; cycle(1'b1);
    chk("rst_halt_win", {15'd0, HALT}, 16'd0);
    chk("rst_hcode", HCODE, 16'd0);
    cpu_read(16'd0);
    chk("keep_dmem0", DD, 16'h0004);
    idle(); IA = 16'd5; cycle(1'b1);
    chk("keep_imem5", ID, 16'h0513);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int sel;
      idle();
      RST = ($urandom_range(0, 39) == 0);
      LDE = ($urandom_range(0, 7) == 0);
      LDI = 1'($urandom);
      LDA = 7'($urandom);
      LDD = 16'($urandom);
      RW  = 1'($urandom);
      sel = $urandom_range(0, 19);
      if (sel < 15) DA = 16'($urandom_range(0, 127));
      else if (sel < 16) DA = 16'h00FF;
      else DA = 16'($urandom);
      IA = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
      dd_drv = 16'($urandom);
      cycle(1'b1);
    end

    // Counter saturation.
    idle(); RST = 1'b1; cycle(1'b1);
    for (int n = 0; n < 65535; n++) begin
      idle(); RW = 1'b0; DA = 16'(n % 128); dd_drv = 16'(n); cycle(1'b0);
    end
    check_all();
    chk("wcnt_max", WCNT, 16'hFFFF);
    cpu_write(16'd10, 16'h5555);
    chk("wcnt_sat", WCNT, 16'hFFFF);
    cpu_read(16'd10);
    chk("sat_data", DD, 16'h5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have ports, clock and reset first: CK in 1 clock; RST in 1 reset; IA in 16 instruction address; ID out 16 instruction data; DA in 16 data address; DD inout 16 bidirectional data bus; RW in 1 (1 = CPU reads, 0 = CPU writes); LDE in 1 loader enable; LDI in 1 loader target (1 = IMEM, 0 = DMEM); LDA in 7 loader address; LDD in 16 loader data; HALT out 1 halt flag; HCODE out 16 halt code; ERR out 1 sticky address error; WCNT out 16 write count.
REQ-002 SHALL use one clock, CK; reset RST is synchronous and active-high.
REQ-003 SHALL update all state on the falling edge of CK, so data is stable for the CPU's next rising edge.

Function
REQ-004 SHALL contain IMEM and DMEM, each 128 x 16; RST SHALL NOT clear either array.
REQ-005 SHALL treat DA/IA values 0x0000-0x007F as in range, using bits [6:0] as the index.
REQ-006 Fetch: SHALL register ID <= IMEM[IA[6:0]] each falling edge when IA is in range, else ID <= 0; latency is one falling edge.
REQ-007 Read: when RW=1, SHALL register the internal read latch <= DMEM[DA[6:0]] (0 if DA is out of range) each falling edge.
REQ-008 DD drive: SHALL drive DD from the read latch combinationally while RW=1, RST=0 and LDE=0; otherwise DD SHALL be high-Z.
REQ-009 Write: at a falling edge with RW=0, LDE=0, RST=0, HALT=0 and DA in range, SHALL store DMEM[DA[6:0]] <= DD.
REQ-010 Each write per REQ-009 SHALL increment WCNT, saturating at 0xFFFF (no wrap).
REQ-011 Halt mailbox: a CPU write (conditions of REQ-009, except DA = 0x00FF) SHALL set HALT=1 and latch HCODE <= DD; DMEM SHALL NOT be written and WCNT SHALL NOT increment.
REQ-012 Any CPU write with DA > 0x007F other than 0x00FF SHALL set ERR=1 and SHALL have no other effect.
REQ-013 HALT and ERR SHALL be sticky until RST.
REQ-014 While HALT=1, SHALL ignore CPU writes; ID SHALL read 0; reads continue per REQ-007.
REQ-015 Loader: at each falling edge with LDE=1, SHALL write LDD to IMEM[LDA] if LDI=1, else to DMEM[LDA].
REQ-016 Loader writes SHALL be accepted during RST=1 and during HALT=1, and SHALL NOT affect WCNT, ERR or HALT.
REQ-017 While LDE=1, SHALL ignore all CPU writes and hold ID at 0.
REQ-018 Same-edge LDE DMEM write and CPU write to the same index: the loader value SHALL win and the CPU write SHALL be dropped (no count).
REQ-019 Write-then-read of the same address on consecutive edges SHALL return the new value (no stale bypass hazard, given REQ-003 ordering).

Reset
REQ-020 At a falling edge with RST=1, SHALL set ID=0, read latch=0, HALT=0, HCODE=0, ERR=0 and WCNT=0.
REQ-021 While RST=1, DD SHALL be high-Z and CPU writes SHALL be ignored.
REQ-022 If RST coincides with a halt or error write, reset SHALL win.
REQ-023 Memory contents SHALL survive reset.

Verification
REQ-024 Preload: RST=1, LDE=1, LDI=1, LDA=0..7 with the IMM/ADD/ST/LD program; release reset; IA=5 -> ID=0x0513 after one falling edge.
REQ-025 Data path: CPU writes 0x0004 to DA=0 with RW=0, then reads with RW=1 -> DD=0x0004, WCNT=1; DD is Z during the write cycle.
REQ-026 Halt: write 0x00AA to DA=0x00FF -> HALT=1, HCODE=0x00AA, WCNT unchanged; a following write of 0x1234 to DA=3 leaves DMEM[3] unchanged and ID=0.
REQ-027 Error/range: write to DA=0x0100 -> ERR=1, no DMEM change; read DA=0x0200 -> DD=0x0000; IA=0x0080 -> ID=0.
REQ-028 Collision and saturation: same-edge loader write of 0x1111 and CPU write of 0x2222 to index 9 -> DMEM[9]=0x1111, WCNT unchanged; force WCNT to 0xFFFF, then one more write -> WCNT stays 0xFFFF.
REQ-029 Reset mid-operation: assert RST the same edge as a DA=0x00FF write -> HALT=0, HCODE=0, previously loaded DMEM/IMEM contents intact.
